l0_loader: RTL
==============

Name: l0_loader

Overview:
- Upstream controller for the L0 input buffer. Streams num_vec row-vectors from activation/weight SRAM into L0 through a 2-entry skid buffer, honouring L0 backpressure.
- Then drains L0 into the array by issuing num_vec read strobes, in either all-rows (mode 0) or staggered (mode 1) read mode.
- Sits between core SRAM and L0; driven by the top-level sequencer via a start/done handshake.

Parameters:
row, 8, number of L0 rows (lanes per vector)
bw, 4, bits per lane
depth, 64, L0 FIFO depth; upper bound on vectors per job
addr_w, 11, SRAM address width

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  job request; sampled only in IDLE
base_addr  input  addr_w  first SRAM address of the job
num_vec  input  7  vectors per job (valid range 1..depth)
mode_in  input  1  L0 read mode for this job (0 all rows, 1 staggered)
sram_cen  output  1  SRAM chip enable, active-low
sram_addr  output  addr_w  SRAM read address
sram_data  input  row*bw  SRAM read data, valid the cycle after a read is issued
l0_in  output  row*bw  write data to L0 (skid head)
l0_wr  output  1  L0 write strobe
l0_o_ready  input  1  L0 not-full
l0_rd  output  1  L0 read strobe
l0_mode  output  1  L0 mode, held for the whole job
busy  output  1  job in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state IDLE, sram_cen=1, sram_addr=0, l0_wr=0, l0_rd=0, l0_mode=0, busy=0, done=0. Skid and counters cleared. Reset mid-job abandons the job with no done pulse.
- FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> TAIL -> DONE -> IDLE.
- IDLE: on start=1, latch base_addr, num_vec and mode_in (mode_in drives l0_mode); go to LOAD. busy=1 from the next cycle through DONE inclusive.
- LOAD: issue read k (k = 0..num_vec-1) with sram_cen=0 and sram_addr = base_addr+k (mod 2^addr_w; wrap allowed).
  - Issue rule: issue only when occ + inflight - pop < 2. occ = skid entries, inflight = read issued last cycle, pop = l0_wr this cycle.
  - When no read is issued, sram_cen=1.
  - After the last issue, go to FLUSH.
- Skid: returning sram_data is pushed at the end of the cycle after issue. l0_in = skid head. l0_wr = (occ>0) & l0_o_ready, evaluated combinationally. Push and pop may occur in the same cycle. Order is preserved.
- Full throughput: with l0_o_ready held at 1, one read is issued per cycle and l0_wr is high in cycles t+2..t+num_vec+1, where t is the first issue cycle.
- l0_o_ready=0: l0_wr=0 and skid content is held. At most 2 further reads issue before stall. No data is lost or duplicated.
- FLUSH: wait until inflight=0 and occ=0, then go to DRAIN.
- DRAIN: l0_rd=1 for exactly num_vec consecutive cycles, then go to TAIL.
- TAIL: wait 1 cycle if l0_mode=0, or row cycles if l0_mode=1 (stagger completion). Then go to DONE.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE with busy=0.
- Boundaries:
  - start while busy is ignored.
  - start in the DONE cycle is ignored; it is accepted only in IDLE.
  - num_vec=0: IDLE -> DONE directly, with no SRAM or L0 activity.
  - num_vec>depth: clipped to depth.

Optional Feature:
- Macro L0_LOADER_ERR_EN.
- Defined: adds output err (1 bit, reset 0).
  - start with num_vec=0 or num_vec>depth is rejected: FSM stays IDLE, no done pulse, err=1 (sticky until reset).
  - A legal start clears err in the acceptance cycle.
- Undefined: no err port; zero/clip handling as in Behaviour.

Test Plan:
- num_vec=4, base_addr=0x010, mode_in=0, l0_o_ready=1 -> addrs 0x010..0x013 on consecutive cycles; 4 l0_wr pulses with data matching SRAM words in order; then 4 l0_rd cycles, 1 TAIL cycle, one done pulse.
- Same job with mode_in=1 -> l0_mode=1 throughout; TAIL lasts 8 cycles before done.
- num_vec=6, l0_o_ready forced 0 for 5 cycles after the first write -> issues stall with occ+inflight<=2; all 6 words written exactly once, in order; no l0_wr while ready=0.
- base_addr=0x7FE, num_vec=4 -> sram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Reset pulled low mid-LOAD, then released, then a new start with num_vec=2 -> all outputs at reset values during reset; no done for the aborted job; new job completes normally. start pulses while busy are ignored.
- num_vec=0 and num_vec=70 -> macro undefined: immediate done, and 64 vectors respectively; macro defined: err=1, no done, busy stays 0.

Source files
------------

// File: rtl/l0_loader.sv
// L0 input-buffer loader: streams SRAM row-vectors into L0 through a 2-entry skid, then drains L0.
// Optional L0_LOADER_ERR_EN adds a sticky err output that rejects zero/oversized jobs.
module l0_loader #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int depth  = 64,
  parameter int addr_w = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [6:0]          num_vec,
  input  logic                mode_in,
  output logic                sram_cen,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_data,
  output logic [row*bw-1:0]   l0_in,
  output logic                l0_wr,
  input  logic                l0_o_ready,
  output logic                l0_rd,
  output logic                l0_mode,
  output logic                busy,
  output logic                done
`ifdef L0_LOADER_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int W = row * bw;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_TAIL, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [6:0]          nv, nv_clip, cnt, cnt_nxt;
  logic [addr_w-1:0]   base;
  logic                mode;
  logic                inflight;
  logic [1:0]          occ;
  logic [1:0][W-1:0]   skid;
  logic                wp, rp;
  logic                issue, pop, push, accept, tail_last;
  logic [2:0]          outst;
`ifdef L0_LOADER_ERR_EN
  logic                err_set, err_clr;
`endif

  assign nv_clip   = (int'(num_vec) > depth) ? 7'(depth) : num_vec;
  assign pop       = (occ != 2'd0) && l0_o_ready;
  assign push      = inflight;
  // Entries that will still occupy the skid next cycle if nothing new is issued.
  assign outst     = 3'(occ) + 3'(inflight) - 3'(pop);
  assign tail_last = mode ? (cnt == 7'(row - 1)) : 1'b1;

  assign l0_wr     = pop;
  assign l0_in     = skid[rp];
  assign l0_rd     = (state == S_DRAIN);
  assign l0_mode   = mode;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign sram_cen  = ~issue;
  assign sram_addr = base + addr_w'(cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    accept    = 1'b0;
`ifdef L0_LOADER_ERR_EN
    err_set   = 1'b0;
    err_clr   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_nxt = 7'd0;
        if (start) begin
`ifdef L0_LOADER_ERR_EN
          if (num_vec == 7'd0 || int'(num_vec) > depth) begin
            err_set = 1'b1;
          end else begin
            accept    = 1'b1;
            err_clr   = 1'b1;
            state_nxt = S_LOAD;
          end
`else
          accept    = 1'b1;
          state_nxt = (num_vec == 7'd0) ? S_DONE : S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        if (outst < 3'd2) begin
          issue = 1'b1;
          if (cnt == nv - 7'd1) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = 7'd0;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      S_FLUSH: if (!inflight && occ == 2'd0) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (cnt == nv - 7'd1) begin
          state_nxt = S_TAIL;
          cnt_nxt   = 7'd0;
        end else begin
          cnt_nxt = cnt + 7'd1;
        end
      end
      S_TAIL: begin
        if (tail_last) begin
          state_nxt = S_DONE;
          cnt_nxt   = 7'd0;
        end else begin
          cnt_nxt = cnt + 7'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      nv       <= '0;
      base     <= '0;
      mode     <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
      skid     <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      inflight <= issue;
      if (accept) begin
        base <= base_addr;
        nv   <= nv_clip;
        mode <= mode_in;
      end
      // SRAM word lands in the skid the cycle after its read was issued.
      if (push) begin
        skid[wp] <= sram_data;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

`ifdef L0_LOADER_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`endif

endmodule
